// File: rtl/msdap_pkg.sv
// Shared MSDAP constants and the output serializer state type.
// Contents: output word width, default inter-frame gap, tx state enum.
package msdap_pkg;

  localparam int MSDAP_OUT_W = 40;
  localparam int TX_GAP_DEF  = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP,
    TX_PARITY
  } tx_state_t;

endpackage

// File: rtl/msdap_serial_tx_if.sv
// Valid/ready result-pair bus from the compute block to the serializer.
// Signals: in_valid, in_ready, in_data_l, in_data_r (two's complement).
interface msdap_serial_tx_if
  import msdap_pkg::*;
#(
  parameter int W = MSDAP_OUT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data_l;
  logic [W-1:0] in_data_r;

  modport master (
    output in_valid,
    output in_data_l,
    output in_data_r,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data_l,
    input  in_data_r,
    output in_ready
  );

endinterface

// File: rtl/msdap_piso_shift.sv
// Parallel-load, MSB-first shift register for one serial channel.
// Ports: sClk, reset_n, i_load, i_shift, i_data; o_next = bit after MSB.
module msdap_piso_shift #(
  parameter int W = 40
) (
  input  logic         sClk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_next
);

  logic [W-1:0] r_sh;

  // MSB of r_sh is the bit on the line; o_next is the one to drive next.
  assign o_next = r_sh[W-2];

  always_ff @(posedge sClk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/msdap_serial_tx.sv
// MSDAP output serializer: L/R word pairs out MSB-first with frame pulse.
// Ports: sClk, reset_n, flush, s_in (slave bus), out_frame,
// out_bit_l, out_bit_r, busy. Option: MSDAP_TX_PARITY_EN adds a
// trailing even-parity cycle per word.
module msdap_serial_tx
  import msdap_pkg::*;
#(
  parameter int WORD_W     = MSDAP_OUT_W,
  parameter int GAP_CYCLES = TX_GAP_DEF
) (
  input  logic             sClk,
  input  logic             reset_n,
  input  logic             flush,
  msdap_serial_tx_if.slave s_in,
  output logic             out_frame,
  output logic             out_bit_l,
  output logic             out_bit_r,
  output logic             busy
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CNT_MSB = CW'(WORD_W - 1);
  localparam logic [CW-1:0] CNT_GAP =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t      r_state, w_nx_state;
  logic [CW-1:0]  r_cnt, w_nx_cnt;
  logic           r_full, w_nx_full;
  logic [WORD_W-1:0] r_buf_l, r_buf_r;
  logic           r_frame, r_bit_l, r_bit_r, r_busy;
  logic           w_frame, w_bit_l, w_bit_r;
  logic           w_load, w_shift, w_take;
  logic           w_eow, w_idle;
  logic           w_next_l, w_next_r;
`ifdef MSDAP_TX_PARITY_EN
  logic           r_par_l, r_par_r;
`endif

  assign s_in.in_ready = !r_full;
  assign w_take = s_in.in_valid && !r_full && !flush;

  assign out_frame = r_frame;
  assign out_bit_l = r_bit_l;
  assign out_bit_r = r_bit_r;
  assign busy      = r_busy;

  msdap_piso_shift #(.W(WORD_W)) u_piso_l (
    .sClk    (sClk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (r_buf_l),
    .o_next  (w_next_l)
  );

  msdap_piso_shift #(.W(WORD_W)) u_piso_r (
    .sClk    (sClk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (r_buf_r),
    .o_next  (w_next_r)
  );

  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_frame    = 1'b0;
    w_bit_l    = 1'b0;
    w_bit_r    = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_eow      = 1'b0;
    w_idle     = 1'b0;
    unique case (r_state)
      TX_IDLE: w_idle = 1'b1;
      TX_SHIFT: begin
        if (r_cnt != '0) begin
          w_shift  = 1'b1;
          w_nx_cnt = r_cnt - 1'b1;
          w_bit_l  = w_next_l;
          w_bit_r  = w_next_r;
        end else begin
`ifdef MSDAP_TX_PARITY_EN
          w_nx_state = TX_PARITY;
          w_bit_l    = r_par_l;
          w_bit_r    = r_par_r;
`else
          w_eow = 1'b1;
`endif
        end
      end
      TX_PARITY: w_eow = 1'b1;
      TX_GAP: begin
        // Last gap cycle is spent in IDLE so a load lands right after it.
        if (r_cnt <= CW'(1)) begin
          w_nx_state = TX_IDLE;
          w_nx_cnt   = '0;
        end else begin
          w_nx_cnt = r_cnt - 1'b1;
        end
      end
      default: w_nx_state = TX_IDLE;
    endcase
    if (w_eow) begin
      if (GAP_CYCLES > 1) begin
        w_nx_state = TX_GAP;
        w_nx_cnt   = CNT_GAP;
      end else if (GAP_CYCLES == 1) begin
        w_nx_state = TX_IDLE;
        w_nx_cnt   = '0;
      end else begin
        w_idle = 1'b1;
      end
    end
    if (w_idle) begin
      if (r_full) begin
        w_load     = 1'b1;
        w_nx_state = TX_SHIFT;
        w_nx_cnt   = CNT_MSB;
        w_frame    = 1'b1;
        w_bit_l    = r_buf_l[WORD_W-1];
        w_bit_r    = r_buf_r[WORD_W-1];
      end else begin
        w_nx_state = TX_IDLE;
        w_nx_cnt   = '0;
      end
    end
    if (flush) begin
      w_nx_state = TX_IDLE;
      w_nx_cnt   = '0;
      w_frame    = 1'b0;
      w_bit_l    = 1'b0;
      w_bit_r    = 1'b0;
      w_load     = 1'b0;
      w_shift    = 1'b0;
    end
    // New word wins over the load: buffer stays full on a same-edge pair.
    if (flush)       w_nx_full = 1'b0;
    else if (w_take) w_nx_full = 1'b1;
    else if (w_load) w_nx_full = 1'b0;
    else             w_nx_full = r_full;
  end

  always_ff @(posedge sClk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
      r_frame <= 1'b0;
      r_bit_l <= 1'b0;
      r_bit_r <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_cnt   <= w_nx_cnt;
      r_full  <= w_nx_full;
      r_frame <= w_frame;
      r_bit_l <= w_bit_l;
      r_bit_r <= w_bit_r;
      r_busy  <= (w_nx_state != TX_IDLE) || w_nx_full;
      if (w_take) begin
        r_buf_l <= s_in.in_data_l;
        r_buf_r <= s_in.in_data_r;
      end
    end
  end

`ifdef MSDAP_TX_PARITY_EN
  always_ff @(posedge sClk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_l <= 1'b0;
      r_par_r <= 1'b0;
    end else if (w_load) begin
      r_par_l <= ^r_buf_l;
      r_par_r <= ^r_buf_r;
    end
  end
`endif

endmodule

// File: tb/tb_msdap_serial_tx.sv
// Bench for msdap_serial_tx: gap-2 and gap-0 instances vs a timeline model.
// Model maps each accepted pair onto expected per-edge outputs.
module tb_msdap_serial_tx;
  import msdap_pkg::*;

  localparam int W  = 40;
  localparam int NE = 4096;
`ifdef MSDAP_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic sClk;
  logic reset_n;
  logic [1:0] vld;
  logic [1:0] fl;
  logic [W-1:0] dl [2];
  logic [W-1:0] dr [2];
  logic f0, f1, l0, l1, r0, r1, b0, b1;
  logic [1:0] o_f, o_l, o_r, o_b, o_rdy;

  msdap_serial_tx_if #(.W(W)) if0 ();
  msdap_serial_tx_if #(.W(W)) if1 ();

  assign if0.in_valid  = vld[0];
  assign if0.in_data_l = dl[0];
  assign if0.in_data_r = dr[0];
  assign if1.in_valid  = vld[1];
  assign if1.in_data_l = dl[1];
  assign if1.in_data_r = dr[1];

  assign o_f   = {f1, f0};
  assign o_l   = {l1, l0};
  assign o_r   = {r1, r0};
  assign o_b   = {b1, b0};
  assign o_rdy = {if1.in_ready, if0.in_ready};

  msdap_serial_tx #(.WORD_W(W), .GAP_CYCLES(2)) u_dut0 (
    .sClk      (sClk),
    .reset_n   (reset_n),
    .flush     (fl[0]),
    .s_in      (if0),
    .out_frame (f0),
    .out_bit_l (l0),
    .out_bit_r (r0),
    .busy      (b0)
  );

  msdap_serial_tx #(.WORD_W(W), .GAP_CYCLES(0)) u_dut1 (
    .sClk      (sClk),
    .reset_n   (reset_n),
    .flush     (fl[1]),
    .s_in      (if1),
    .out_frame (f1),
    .out_bit_l (l1),
    .out_bit_r (r1),
    .busy      (b1)
  );

  initial begin
    sClk = 1'b0;
    forever #5 sClk = ~sClk;
  end

  int  n_vec;
  int  n_err;
  int  k;
  bit  ef   [2][NE];
  bit  el   [2][NE];
  bit  er   [2][NE];
  bit  erdy [2][NE];
  bit  eb   [2][NE];
  int  free_e [2];
  int  last_l [2];
  logic [1:0] acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [W-1:0] rnd40();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic clear_model(input int d, input int from);
    for (int j = from; j < NE; j++) begin
      ef[d][j]   = 1'b0;
      el[d][j]   = 1'b0;
      er[d][j]   = 1'b0;
      eb[d][j]   = 1'b0;
      erdy[d][j] = 1'b1;
    end
    free_e[d] = 0;
  endtask

  // Word accepted at edge e: loads at the first free edge after e,
  // then occupies WORD_W (+parity) bit cycles and the gap.
  task automatic sched(input int d, input int e,
                       input logic [W-1:0] wl, input logic [W-1:0] wr);
    int l;
    int span;
    l    = (e + 1 > free_e[d]) ? e + 1 : free_e[d];
    span = W + PAR + gap_of(d);
    if (l + span >= NE) begin
      $display("FAIL model range: edge %0d beyond %0d", l + span, NE);
      $fatal(1);
    end
    ef[d][l] = 1'b1;
    for (int i = 0; i < W; i++) begin
      el[d][l+i] = wl[W-1-i];
      er[d][l+i] = wr[W-1-i];
    end
    if (PAR == 1) begin
      el[d][l+W] = ^wl;
      er[d][l+W] = ^wr;
    end
    for (int j = e; j < l; j++) erdy[d][j] = 1'b0;
    for (int j = e; j < l + span - 1; j++) eb[d][j] = 1'b1;
    free_e[d] = l + span;
    last_l[d] = l;
  endtask

  task automatic compare(input int kk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d frame e%0d", d, kk), o_f[d], ef[d][kk]);
      chk($sformatf("d%0d bit_l e%0d", d, kk), o_l[d], el[d][kk]);
      chk($sformatf("d%0d bit_r e%0d", d, kk), o_r[d], er[d][kk]);
      chk($sformatf("d%0d ready e%0d", d, kk), o_rdy[d], erdy[d][kk]);
      if (d == 0)
        chk($sformatf("d0 busy e%0d", kk), o_b[0], eb[0][kk]);
    end
  endtask

  task automatic cycle();
    @(posedge sClk);
    k++;
    for (int d = 0; d < 2; d++) begin
      acc[d] = 1'b0;
      if (fl[d]) begin
        clear_model(d, k);
      end else if (vld[d] && erdy[d][k-1]) begin
        acc[d] = 1'b1;
        sched(d, k, dl[d], dr[d]);
      end
    end
    @(negedge sClk);
    compare(k);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic offer(input int d, input logic [W-1:0] wl,
                       input logic [W-1:0] wr, input bit keep,
                       output int e);
    vld[d] = 1'b1;
    dl[d]  = wl;
    dr[d]  = wr;
    e      = -1;
    for (int n = 0; n < 300 && e < 0; n++) begin
      cycle();
      if (acc[d]) e = k;
    end
    vld[d] = keep;
  endtask

  task automatic rst_cycle();
    @(posedge sClk);
    k++;
    acc = '0;
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d async frame", d), o_f[d], 1'b0);
      chk($sformatf("d%0d async bit_l", d), o_l[d], 1'b0);
      chk($sformatf("d%0d async bit_r", d), o_r[d], 1'b0);
      chk($sformatf("d%0d async ready", d), o_rdy[d], 1'b1);
      clear_model(d, k);
    end
    chk("d0 async busy", o_b[0], 1'b0);
    #1 reset_n = 1'b1;
    @(negedge sClk);
    compare(k);
  endtask

  initial begin
    int e;
    int e1;
    int l1;
    n_vec   = 0;
    n_err   = 0;
    k       = 0;
    acc     = '0;
    vld     = '0;
    fl      = '0;
    dl[0]   = '0;
    dl[1]   = '0;
    dr[0]   = '0;
    dr[1]   = '0;
    reset_n = 1'b1;
    clear_model(0, 0);
    clear_model(1, 0);
    #1 reset_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset frame", d), o_f[d], 1'b0);
      chk($sformatf("d%0d reset bit_l", d), o_l[d], 1'b0);
      chk($sformatf("d%0d reset bit_r", d), o_r[d], 1'b0);
      chk($sformatf("d%0d reset ready", d), o_rdy[d], 1'b1);
      chk($sformatf("d%0d reset busy", d), o_b[d], 1'b0);
    end
    #5 reset_n = 1'b1;

    offer(0, 40'h8000000001, 40'h00000000FF, 1'b0, e);
    idle(50);

    offer(1, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 1'b1, e);
    offer(1, 40'h0, 40'h0, 1'b0, e);
    idle(90);

    for (int i = 0; i < 3; i++)
      offer(0, rnd40(), rnd40(), (i < 2), e);
    idle(90);

    offer(0, rnd40(), rnd40(), 1'b0, e1);
    l1 = last_l[0];
    offer(0, rnd40(), rnd40(), 1'b0, e);
    for (int n = 0; n < 100 && k < l1 + 18; n++) cycle();
    fl[0]  = 1'b1;
    vld[0] = 1'b1;
    dl[0]  = rnd40();
    dr[0]  = rnd40();
    cycle();
    fl[0]  = 1'b0;
    vld[0] = 1'b0;
    idle(5);
    offer(0, rnd40(), rnd40(), 1'b0, e);
    idle(50);

    offer(0, rnd40(), rnd40(), 1'b0, e);
    offer(0, rnd40(), rnd40(), 1'b0, e);
    idle(15);
    rst_cycle();
    idle(10);
    offer(0, rnd40(), rnd40(), 1'b0, e);
    idle(50);

    offer(0, 40'h0000000007, rnd40(), 1'b1, e);
    offer(0, rnd40(), 40'h0000000007, 1'b0, e);
    idle(100);

    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 30));
      offer(i % 2, rnd40(), rnd40(), 1'($urandom_range(0, 1)), e);
    end
    vld = '0;
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
